// File: rtl/fifo_drain_stream_if.sv
// rtl/fifo_drain_stream_if.sv - FIFO pop port and downstream stream bundle for fifo_drain_stream
interface fifo_drain_stream_if #(
    parameter int DATA_W = 32
);
    logic              fifo_empty;
    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_pop_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    // Drain controller side: pops the FIFO and sources the stream
    modport master (
        input  fifo_empty,
        input  fifo_pop_data,
        input  out_ready,
        output fifo_pop,
        output out_valid,
        output out_data,
        output out_last
    );

    // Environment side: the FIFO plus the streaming consumer
    modport slave (
        output fifo_empty,
        output fifo_pop_data,
        output out_ready,
        input  fifo_pop,
        input  out_valid,
        input  out_data,
        input  out_last
    );
endinterface

// File: rtl/fifo_drain_stream.sv
// rtl/fifo_drain_stream.sv - FIFO read-side drain into a 2-entry skid buffer with burst framing
module fifo_drain_stream #(
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rstn,      // active-high synchronous reset
    input  logic                 en,
    fifo_drain_stream_if.master  bus,
    output logic [CNT_W-1:0]     tx_count,
    output logic                 busy
);
    localparam int                BIDX_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(BURST_LEN - 1);

    logic [1:0]        occ_q, occ_d;
    logic              inflight_q;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;
    logic [BIDX_W-1:0] bidx_q, bidx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              hs;
    logic [2:0]        credit;

    assign hs = bus.out_valid & bus.out_ready;

    // Entries plus the word in flight may never exceed two after this cycle's handshake,
    // which is what keeps the skid buffer from overflowing. No pops while in reset.
    assign credit       = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, hs};
    assign bus.fifo_pop = en & ~bus.fifo_empty & ~rstn & (credit < 3'd2);

    assign bus.out_valid = (occ_q != 2'd0);
    assign bus.out_data  = (occ_q != 2'd0) ? head_q : '0;
    assign bus.out_last  = bus.out_valid & (bidx_q == BIDX_LAST);
    assign tx_count      = cnt_q;
    assign busy          = inflight_q | (occ_q != 2'd0);

    // Next buffer contents: the head leaves first, then the arriving word joins at the tail
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        bidx_d = bidx_q;
        cnt_d  = cnt_q;
        if (hs) begin
            head_d = tail_q;
            occ_d  = occ_q - 2'd1;
            bidx_d = (bidx_q == BIDX_LAST) ? '0 : bidx_q + 1'b1;
            cnt_d  = cnt_q + 1'b1;
        end
        if (inflight_q) begin
            if (occ_d == 2'd0) begin
                head_d = bus.fifo_pop_data;
            end else begin
                tail_d = bus.fifo_pop_data;
            end
            occ_d = occ_d + 2'd1;
        end
    end

    // State registers; a word still in flight at reset is dropped
    always_ff @(posedge clk) begin
        if (rstn) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            bidx_q     <= '0;
            cnt_q      <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= bus.fifo_pop;
            head_q     <= head_d;
            tail_q     <= tail_d;
            bidx_q     <= bidx_d;
            cnt_q      <= cnt_d;
        end
    end
endmodule

// File: tb/tb_fifo_drain_stream.sv
// tb/tb_fifo_drain_stream.sv - scoreboard bench for fifo_drain_stream against a queue model
module tb_fifo_drain_stream;
    localparam int DATA_W    = 32;
    localparam int BURST_LEN = 4;
    localparam int CNT_W     = 4;

    logic             clk = 1'b0;
    logic             rstn;
    logic             en;
    logic [CNT_W-1:0] tx_count;
    logic             busy;

    fifo_drain_stream_if #(.DATA_W(DATA_W)) bus ();

    fifo_drain_stream #(.DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .en       (en),
        .bus      (bus),
        .tx_count (tx_count),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] src_q[$];   // contents of the FIFO being drained
    logic [DATA_W-1:0] exp_q[$];   // popped words not yet delivered, in order
    int  vectors = 0;
    int  errs    = 0;
    int  hs_n    = 0;              // handshakes since the last reset
    int  pop_cnt = 0;
    bit  in_fl   = 1'b0;           // a word was popped last cycle
    bit  prev_rst = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Monitor: compare the DUT against the model, then retire handshaken words
    always @(negedge clk) begin
        bit exp_valid, exp_pop, exp_hs;
        if (rstn) begin
            chk("pop_in_reset", 64'(bus.fifo_pop), 64'd0);
            exp_q.delete();
            hs_n     = 0;
            in_fl    = 1'b0;
            prev_rst = 1'b1;
        end else begin
            if (prev_rst) begin
                chk("post_reset_outs", {tx_count, busy, bus.out_last, bus.out_valid, bus.out_data}, 64'd0);
            end
            exp_valid = (exp_q.size() > int'(in_fl));
            exp_hs    = exp_valid & bus.out_ready;
            exp_pop   = en & ~bus.fifo_empty & ((exp_q.size() - int'(exp_hs)) < 2);
            chk("busy", 64'(busy), 64'(exp_q.size() != 0));
            chk("out_valid", 64'(bus.out_valid), 64'(exp_valid));
            chk("fifo_pop", 64'(bus.fifo_pop), 64'(exp_pop));
            if (exp_valid && bus.out_valid) begin
                chk("out_data", 64'(bus.out_data), 64'(exp_q[0]));
                chk("out_last", 64'(bus.out_last), 64'((hs_n % BURST_LEN) == BURST_LEN - 1));
                chk("tx_count", 64'(tx_count), 64'(hs_n % (1 << CNT_W)));
                if (bus.out_ready) begin
                    void'(exp_q.pop_front());
                    hs_n++;
                end
            end
            in_fl    = bus.fifo_pop;
            prev_rst = 1'b0;
        end
    end

    // One clock: observe this cycle's pop, then apply FIFO read data and next inputs
    task automatic cyc(input bit rst, input bit e, input bit rdy, input int npush);
        bit p;
        @(negedge clk);
        p = bus.fifo_pop;
        @(posedge clk);
        #1;
        rstn = rst;
        en = e;
        bus.out_ready = rdy;
        if (p) begin
            pop_cnt++;
            if (src_q.size() == 0) begin
                errs++;
                $display("FAIL pop_on_empty: popped with no data in FIFO");
                bus.fifo_pop_data = $urandom;
            end else begin
                bus.fifo_pop_data = src_q.pop_front();
                exp_q.push_back(bus.fifo_pop_data);
            end
        end else begin
            bus.fifo_pop_data = $urandom;
        end
        for (int i = 0; i < npush; i++) src_q.push_back($urandom);
        bus.fifo_empty = (src_q.size() == 0);
    endtask

    initial begin
        logic [DATA_W-1:0] w0;
        rstn = 1'b1;
        en = 1'b1;
        bus.out_ready = 1'b1;
        bus.fifo_pop_data = '0;
        for (int i = 0; i < 8; i++) src_q.push_back(32'hA0 + i);
        bus.fifo_empty = 1'b0;

        // reset held with data available
        repeat (3) cyc(1, 1, 1, 0);

        // streaming A0..A7
        repeat (14) cyc(0, 1, 1, 0);
        chk("stream_count", 64'(hs_n), 64'd8);

        // backpressure with four words queued
        pop_cnt = 0;
        cyc(0, 1, 0, 4);
        w0 = src_q[0];
        repeat (9) cyc(0, 1, 0, 0);
        chk("bp_pops", 64'(pop_cnt), 64'd2);
        @(negedge clk);
        chk("bp_hold", 64'(bus.out_data), 64'(w0));
        repeat (8) cyc(0, 1, 1, 0);

        // enable gating, then resume
        cyc(0, 1, 1, 6);
        repeat (2) cyc(0, 1, 1, 0);
        repeat (6) cyc(0, 0, 1, 0);
        @(negedge clk);
        chk("busy_after_drain", 64'(busy), 64'd0);
        repeat (12) cyc(0, 1, 1, 0);

        // single word, FIFO empty while it is in flight
        cyc(0, 1, 1, 1);
        repeat (6) cyc(0, 1, 1, 0);

        // reset with the buffer full
        repeat (5) cyc(0, 1, 0, 5);
        cyc(1, 1, 0, 0);
        repeat (16) cyc(0, 1, 1, 0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) < 8),
                ($urandom_range(0, 9) < 6), (src_q.size() < 6) ? $urandom_range(0, 2) : 0);
        end

        // drain
        repeat (20) cyc(0, 1, 1, 0);
        chk("final_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
